// File: rtl/step_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// step_counter : parametrised up/down step counter with load, wrap/saturate,
//                terminal count and overflow/underflow pulses.
// Optional macro STEP_COUNTER_PRESCALE_EN adds a PRESCALE-cycle step divider.
// Revision 1.0
// -----------------------------------------------------------------------------
module step_counter #(
   parameter int WIDTH     = 4,
   parameter int UP_STEP   = 3,
   parameter int DOWN_STEP = 5,
   parameter int PRESCALE  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH:0]   UP_W = (WIDTH+1)'(UP_STEP);
   localparam logic [WIDTH:0]   DN_W = (WIDTH+1)'(DOWN_STEP);

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("step_counter: WIDTH out of range 2..16");
   end
   if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $error("step_counter: PRESCALE out of range 1..256");
   end

   logic             step_fire;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_next;
   logic             ovf_next;
   logic             unf_next;

`ifdef STEP_COUNTER_PRESCALE_EN
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] prescaler;

   // Prescaler only moves on enabled cycles; load and reset restart the interval.
   always_ff @(posedge clk) begin
      if (!rst || load) begin
         prescaler <= '0;
      end else if (en) begin
         prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      end
   end

   assign step_fire = en && (prescaler == PS_LAST);
`else
   assign step_fire = en;
`endif

   // Bit WIDTH of sum flags a carry past MAX; bit WIDTH of diff flags a borrow.
   always_comb begin
      sum      = {1'b0, q} + UP_W;
      diff     = {1'b0, q} - DN_W;
      q_next   = q;
      ovf_next = 1'b0;
      unf_next = 1'b0;
      if (s) begin
         if (sum[WIDTH]) begin
            ovf_next = 1'b1;
            q_next   = sat ? MAX : sum[WIDTH-1:0];
         end else begin
            q_next   = sum[WIDTH-1:0];
         end
      end else begin
         if (diff[WIDTH]) begin
            unf_next = 1'b1;
            q_next   = sat ? '0 : diff[WIDTH-1:0];
         end else begin
            q_next   = diff[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q   <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (load) begin
         q   <= d;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (step_fire) begin
         q   <= q_next;
         ovf <= ovf_next;
         unf <= unf_next;
      end else begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end
   end

   assign tc = (s && (q == MAX)) || (!s && (q == '0));

endmodule
`default_nettype wire

// File: tb/tb_step_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_step_counter : scoreboard bench for step_counter with default parameters.
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_step_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       s = 1'b1;
   logic       sat = 1'b0;
   logic       load = 1'b0;
   logic [3:0] d = 4'd0;
   logic [3:0] q;
   logic       tc;
   logic       ovf;
   logic       unf;

   typedef struct {
      logic [3:0] q;
      logic       ovf;
      logic       unf;
      logic       tc;
      int         id;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;

   step_counter dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .s    (s),
      .sat  (sat),
      .load (load),
      .d    (d),
      .q    (q),
      .tc   (tc),
      .ovf  (ovf),
      .unf  (unf)
   );

   always #5 clk = ~clk;

   // Drive one cycle on the falling edge and queue the state expected after
   // the following rising edge; glitch pulses rst low between edges.
   task automatic cyc(input logic r, input logic e, input logic s_i, input logic sat_i,
                      input logic ld, input logic [3:0] d_i, input logic [3:0] eq,
                      input logic eo, input logic eu, input logic et, input bit glitch);
      exp_t x;
      @(negedge clk);
      rst  = r;
      en   = e;
      s    = s_i;
      sat  = sat_i;
      load = ld;
      d    = d_i;
      vec_id++;
      x.q = eq; x.ovf = eo; x.unf = eu; x.tc = et; x.id = vec_id;
      expq.push_back(x);
      if (glitch) begin
         #1 rst = 1'b0;
         #2 rst = 1'b1;
      end
   endtask

   // Monitor: the counter presents a new output every rising edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            x = expq.pop_front();
            checks++;
            if (q !== x.q) begin
               errors++;
               $display("FAIL q vec %0d: got %0d expected %0d", x.id, q, x.q);
            end
            if (ovf !== x.ovf) begin
               errors++;
               $display("FAIL ovf vec %0d: got %b expected %b", x.id, ovf, x.ovf);
            end
            if (unf !== x.unf) begin
               errors++;
               $display("FAIL unf vec %0d: got %b expected %b", x.id, unf, x.unf);
            end
            if (tc !== x.tc) begin
               errors++;
               $display("FAIL tc vec %0d: got %b expected %b", x.id, tc, x.tc);
            end
         end
      end
   end

   initial begin
      int wait_cycles;
      //     r e s t l d    q  o u tc g
      // Reset, then count up and wrap 15 -> 2.
      cyc(0,0,1,0,0, 0,  0, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  3, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  6, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  9, 0,0,0, 0);
      cyc(1,1,1,0,0, 0, 12, 0,0,0, 0);
      cyc(1,1,1,0,0, 0, 15, 0,0,1, 0);
      cyc(1,1,1,0,0, 0,  2, 1,0,0, 0);
      // Load 4 and wrap downward.
      cyc(1,0,0,0,1, 4,  4, 0,0,0, 0);
      cyc(1,1,0,0,0, 0, 15, 0,1,0, 0);
      cyc(1,1,0,0,0, 0, 10, 0,0,0, 0);
      // Saturate at MAX, then at zero.
      cyc(1,0,1,1,1,14, 14, 0,0,0, 0);
      cyc(1,1,1,1,0, 0, 15, 1,0,1, 0);
      cyc(1,1,1,1,0, 0, 15, 1,0,1, 0);
      cyc(1,1,1,1,0, 0, 15, 1,0,1, 0);
      cyc(1,1,0,1,0, 0, 10, 0,0,0, 0);
      cyc(1,1,0,1,0, 0,  5, 0,0,0, 0);
      cyc(1,1,0,1,0, 0,  0, 0,0,1, 0);
      cyc(1,1,0,1,0, 0,  0, 0,1,1, 0);
      // Mid-cycle reset glitch is ignored; sampled reset beats load.
      cyc(1,0,1,0,1, 9,  9, 0,0,0, 0);
      cyc(1,1,1,0,0, 0, 12, 0,0,0, 1);
      cyc(0,1,1,0,1, 7,  0, 0,0,0, 0);
      // Load beats enable, then hold.
      cyc(1,1,1,0,1, 7,  7, 0,0,0, 0);
      cyc(1,0,1,0,0, 0,  7, 0,0,0, 0);
      cyc(1,0,1,0,0, 0,  7, 0,0,0, 0);
      cyc(1,0,1,0,0, 0,  7, 0,0,0, 0);
      // Wrap down from 2 to 13.
      cyc(1,0,0,0,1, 2,  2, 0,0,0, 0);
      cyc(1,1,0,0,0, 0, 13, 0,1,0, 0);
      // Reset with s=0 shows tc at zero.
      cyc(0,1,0,0,0, 0,  0, 0,0,1, 0);
`ifdef STEP_COUNTER_PRESCALE_EN
      // Prescale by 4, including a 2-cycle enable gap.
      cyc(1,0,1,0,1, 0,  0, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  0, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  0, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  0, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  3, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  3, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  3, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  3, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  6, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  6, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  6, 0,0,0, 0);
      cyc(1,0,1,0,0, 0,  6, 0,0,0, 0);
      cyc(1,0,1,0,0, 0,  6, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  6, 0,0,0, 0);
      cyc(1,1,1,0,0, 0,  9, 0,0,0, 0);
`endif
      wait_cycles = 0;
      while (expq.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (expq.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/step_counter.md
Name: step_counter

Overview:
Parametrised synchronous up/down step counter, successor to the fixed 4-bit +3/-5 counter.
- Width, up step and down step are set by parameters.
- Adds parallel load, wrap or saturate overflow mode, a terminal-count flag and one-cycle overflow/underflow pulses.
- Used as a programmable sequence/address generator in the lab datapath designs.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.
UP_STEP, 3, increment applied when counting up; legal range 1..2^WIDTH-1.
DOWN_STEP, 5, decrement applied when counting down; legal range 1..2^WIDTH-1.
PRESCALE, 4, cycles per count advance; used only when STEP_COUNTER_PRESCALE_EN is defined; legal range 1..256.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
en  input  1  active-high count enable; 0 = hold.
s  input  1  direction select: 1 = up by UP_STEP, 0 = down by DOWN_STEP.
sat  input  1  mode: 1 = saturate at the limits, 0 = wrap modulo 2^WIDTH.
load  input  1  active-high synchronous parallel load.
d  input  WIDTH  load value.
q  output  WIDTH  registered count.
tc  output  1  terminal count, combinational from q and s.
ovf  output  1  registered one-cycle pulse: an up step crossed 2^WIDTH-1.
unf  output  1  registered one-cycle pulse: a down step crossed 0.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst). rst=0 at a rising edge sets q=0, ovf=0, unf=0 (and prescaler=0) on that edge. No asynchronous path; rst falling between edges does not change q.
- Priority at each edge: rst=0 > load=1 > en=1 > hold.
- Load: q<=d. ovf=0, unf=0. Prescaler is cleared. Load ignores en, s and sat.
- Hold (en=0, load=0): q unchanged; ovf=0, unf=0.
- Count (en=1): computed in WIDTH+1 bits; MAX = 2^WIDTH-1.
  - Up, sum = q+UP_STEP:
    - sum<=MAX: q<=sum, ovf=0.
    - sum>MAX and sat=0: q<=sum mod 2^WIDTH, ovf=1.
    - sum>MAX and sat=1: q<=MAX, ovf=1.
  - Down:
    - q>=DOWN_STEP: q<=q-DOWN_STEP, unf=0.
    - q<DOWN_STEP and sat=0: q<=(q-DOWN_STEP) mod 2^WIDTH, unf=1.
    - q<DOWN_STEP and sat=1: q<=0, unf=1.
  - Saturated hold: saturating while already at the limit (q=MAX up, or q=0 down) keeps q and still pulses ovf or unf each enabled cycle.
- ovf and unf are never both 1. Each lasts exactly one cycle per offending step.
- tc = (s & q==MAX) | (~s & q==0). It follows s combinationally and is valid in every non-reset cycle.
- s, sat and d may change on any cycle; only values at the edge matter.
- Latency: q reflects a load or step one edge after the input is sampled.

Optional Feature:
Macro STEP_COUNTER_PRESCALE_EN.
- Defined: an internal counter of ceil(log2(PRESCALE)) bits (minimum 1) advances on every en=1 cycle.
  - A count step, with its ovf/unf pulse, occurs only on the en cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - en=0 freezes the prescaler.
  - load and rst clear the prescaler.
  - PRESCALE=1 is identical to the macro undefined.
- Undefined: no prescaler logic; every en=1 cycle steps.

Test Plan:
1. Defaults, rst=0 one edge then en=1, s=1, sat=0 -> q 0,3,6,9,12,15,2. ovf=1 only on the 15->2 edge. tc=1 while q=15.
2. load=1, d=4, then en=1, s=0, sat=0 -> q 4, then 15 (4-5 mod 16) with unf=1. Next edge q=10, unf=0.
3. sat=1, load d=14, en=1, s=1 -> q=15, ovf=1. Further edges: q stays 15, ovf=1 each cycle. Switch s=0 -> q=10, ovf=0.
4. Counting at q=9: drive rst=0 mid-cycle, then raise it before the edge -> q unchanged. Hold rst=0 across an edge -> q=0, ovf=unf=0 on that edge.
5. load=1 and en=1 together with d=7, s=1 -> q=7, no step applied. Then en=0 for 3 edges -> q stays 7, tc=0.
6. STEP_COUNTER_PRESCALE_EN defined, PRESCALE=4, en=1, s=1 from q=0 -> q=3 after 4 edges, q=6 after 8 edges. Drop en for 2 cycles mid-interval -> the step is delayed by exactly 2 cycles.
